// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth op codes,
// default operand width and the op decoder.
package mult_pkg;

  localparam int MULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding of {Q[0], q_m1}.
  function automatic booth_op_e decode_op(input logic [1:0] bits);
    booth_op_e op;
    case (bits)
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_datapath.sv
// Booth accumulator/shift datapath: A/Qr/q_m1/Mr registers, add/sub/pass select
// and the arithmetic right shift of {A, Qr, q_m1}.
module booth_datapath
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  booth_op_e       op_i,
  input  logic [N-1:0]    multiplicand_i,
  input  logic [N-1:0]    multiplier_i,
  output logic [1:0]      op_bits_o,
  output logic [2*N-1:0]  prod_next_o
);

  // A and Mr carry one extra bit so that subtracting M = -2^(N-1) cannot overflow.
  logic [N:0]   a_q, a_d, m_q, m_d;
  logic [N-1:0] q_q, q_d;
  logic         qm1_q, qm1_d;

  logic [N:0]   a_sum;
  logic [N:0]   a_sh;
  logic [N-1:0] q_sh;

  always_comb begin
    a_sum = a_q;
    case (op_i)
      OP_ADD:  a_sum = a_q + m_q;
      OP_SUB:  a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    a_sh = {a_sum[N], a_sum[N:1]};
    q_sh = {a_sum[0], q_q[N-1:1]};
  end

  always_comb begin
    a_d   = a_q;
    m_d   = m_q;
    q_d   = q_q;
    qm1_d = qm1_q;
    if (load_i) begin
      a_d   = '0;
      m_d   = {multiplicand_i[N-1], multiplicand_i};
      q_d   = multiplier_i;
      qm1_d = 1'b0;
    end else if (step_i) begin
      a_d   = a_sh;
      q_d   = q_sh;
      qm1_d = q_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      m_q   <= m_d;
      q_q   <= q_d;
      qm1_q <= qm1_d;
    end
  end

  assign op_bits_o   = {q_q[0], qm1_q};
  assign prod_next_o = {a_sh[N-1:0], q_sh};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier: start/ready/done controller and
// iteration counter driving booth_datapath; N iterations per product.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    multiplicand,
  input  logic [N-1:0]    multiplier,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [2*N-1:0]  product
);

  localparam int CW = $clog2(N + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*N-1:0]    product_q, product_d;

  logic              load, step;
  booth_op_e         op;
  logic [1:0]        op_bits;
  logic [2*N-1:0]    prod_next;

  booth_datapath #(.N(N)) u_datapath (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_i         (load),
    .step_i         (step),
    .op_i           (op),
    .multiplicand_i (multiplicand),
    .multiplier_i   (multiplier),
    .op_bits_o      (op_bits),
    .prod_next_o    (prod_next)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    product_d = product_q;
    load      = 1'b0;
    step      = 1'b0;
    op        = OP_NOP;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load    = 1'b1;
          count_d = CW'(N);
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        step    = 1'b1;
        op      = decode_op(op_bits);
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          product_d = prod_next;
          state_d   = DONE;
        end
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        // Back-to-back accept: reload straight from DONE without an IDLE bubble.
        if (start) begin
          load    = 1'b1;
          count_d = CW'(N);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: stimulus pushes expected products and
// done cycles; a negedge monitor pops and compares on every done pulse.
module tb_booth_mult_seq;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [N-1:0]    multiplicand = '0;
  logic [N-1:0]    multiplier = '0;
  logic            ready, busy, done;
  logic [2*N-1:0]  product;

  booth_mult_seq #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] prod;
    int             cyc;
    string          name;
  } exp_t;

  exp_t           sb[$];
  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;
  logic [2*N-1:0] prev_product = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: handshake consistency, product hold, and scoreboard pop on done.
  always @(negedge clk) begin
    if (rst_n) begin
      check(busy === ~ready, "busy_vs_ready", {31'd0, busy}, {31'd0, ~ready});
      if (done) begin
        check(ready === 1'b1, "done_implies_ready", {31'd0, ready}, 32'd1);
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(product === e.prod, {e.name, "_product"}, {16'd0, product}, {16'd0, e.prod});
          check(cyc == e.cyc, {e.name, "_done_cycle"}, cyc, e.cyc);
          $display("txn %s: product=%h done_cycle=%0d", e.name, product, cyc);
        end
      end else begin
        check(product === prev_product, "product_hold", {16'd0, product}, {16'd0, prev_product});
      end
    end
    prev_product <= product;
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check(1'b0, "ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  // Issue one multiply at a negedge; returns the accepting edge index k.
  task automatic do_mult(input logic [N-1:0] m, input logic [N-1:0] q,
                         input logic [2*N-1:0] exp, input string name, output int k);
    exp_t e;
    @(negedge clk);
    wait_ready();
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    k            = cyc + 1;
    e.prod = exp; e.cyc = k + N; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = ~m;
    multiplier   = q + 8'd37;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(sb.size() == 0, "drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    int k, nb;
    exp_t e;

    #2 rst_n = 1'b0;
    #1;
    check(product === '0, "reset_product", {16'd0, product}, 32'd0);
    check(ready === 1'b1 && busy === 1'b0 && done === 1'b0, "reset_flags",
          {29'd0, ready, busy, done}, 32'b100);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Basic run with busy-duration and ready checks.
    do_mult(8'd3, 8'd4, 16'h000C, "m3_q4", k);
    nb = 0;
    repeat (N + 2) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
    end
    check(nb == N, "busy_cycles", nb, N);
    check(ready === 1'b1, "ready_after_done", {31'd0, ready}, 32'd1);

    do_mult(8'hFB, 8'd7,  16'hFFDD, "m-5_q7", k);  drain();
    do_mult(8'd7,  8'hFB, 16'hFFDD, "m7_q-5", k);  drain();
    do_mult(8'h80, 8'h80, 16'h4000, "mmin_qmin", k); drain();
    do_mult(8'h80, 8'h7F, 16'hC080, "mmin_qmax", k); drain();
    do_mult(8'h00, 8'h80, 16'h0000, "m0_qmin", k); drain();

    // Start pulses mid-run with different operands must be ignored.
    do_mult(8'd9, 8'd10, 16'h005A, "ignore_start", k);
    @(negedge clk);
    multiplicand = 8'd100; multiplier = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    multiplicand = 8'hC3; multiplier = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (N + 3) @(negedge clk);

    // Back-to-back: start held through DONE picks up 2 * -3 with no IDLE cycle.
    @(negedge clk);
    wait_ready();
    multiplicand = 8'd5; multiplier = 8'd5; start = 1'b1;
    k = cyc + 1;
    e.prod = 16'h0019; e.cyc = k + N;         e.name = "b2b_first";  sb.push_back(e);
    e.prod = 16'hFFFA; e.cyc = k + 2 * N + 1; e.name = "b2b_second"; sb.push_back(e);
    @(negedge clk);
    multiplicand = 8'd2; multiplier = 8'hFD;
    while (cyc < k + N + 1) @(negedge clk);
    start = 1'b0;
    check(busy === 1'b1, "b2b_no_idle", {31'd0, busy}, 32'd1);
    drain();

    // Asynchronous reset between edges in the middle of a run.
    do_mult(8'd3, 8'd3, 16'h0009, "aborted", k);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check(product === '0, "async_rst_product", {16'd0, product}, 32'd0);
    check(ready === 1'b1 && busy === 1'b0 && done === 1'b0, "async_rst_flags",
          {29'd0, ready, busy, done}, 32'b100);
    @(negedge clk);
    #3 rst_n = 1'b1;
    do_mult(8'd6, 8'd6, 16'h0024, "after_reset", k);
    drain();

    repeat (3) @(negedge clk);
    check(sb.size() == 0, "scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
